mips_mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the pipelined core's fetch port (IF) and its data port (DM).

---
 rtl/mips_pkg.sv | 12 +
 rtl/mips_mem_watchdog.sv | 29 ++
 rtl/mips_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mips_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS unified-memory arbiter.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    DM_BUSY = 2'd2
  } arb_state_e;

  localparam logic [31:0] BUS_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mips_mem_watchdog.sv
// Busy-cycle watchdog for the memory arbiter; only built with MIPS_MEM_TIMEOUT_EN.
`ifdef MIPS_MEM_TIMEOUT_EN
module mips_mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= count + 8'd1;
    end
  end

  // Fires during the last allowed busy cycle so the access closes after exactly TIMEOUT_CYCLES.
  assign expired = run & (count == 8'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mips_mem_arbiter.sv
// Arbitrates the core's fetch (IF) and data (DM) ports onto one req/ack memory.
// Optional watchdog and bus_err flag are enabled by defining MIPS_MEM_TIMEOUT_EN.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DM_STREAK  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              core_stall,
  output logic              bus_err
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_e          state;
  logic [STREAK_W-1:0] streak;
  logic                if_elig, dm_elig, grant_if, grant_dm, timeout;

  // A requester whose completion pulse is showing is still holding its old request.
  always_comb begin
    if_elig  = if_req & ~if_valid;
    dm_elig  = dm_req & ~dm_valid;
    grant_dm = (state == IDLE) & dm_elig & ~(if_elig & (streak == STREAK_MAX));
    grant_if = (state == IDLE) & if_elig & ~grant_dm;
  end

  assign core_stall = rst_n & ((if_req & ~if_valid) | (dm_req & ~dm_valid));

`ifdef MIPS_MEM_TIMEOUT_EN
  mips_mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (grant_if | grant_dm),
    .run     (state != IDLE),
    .expired (timeout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_err <= 1'b0;
    end else if (timeout & ~mem_ack) begin
      bus_err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            state     <= DM_BUSY;
            if (!if_req)                 streak <= '0;
            else if (streak < STREAK_MAX) streak <= streak + STREAK_W'(1);
          end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            state     <= IF_BUSY;
            streak    <= '0;
          end
        end
        IF_BUSY: begin
          if (mem_ack) begin
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (timeout) begin
            if_rdata <= DATA_W'(BUS_ERR_DATA);
            if_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        DM_BUSY: begin
          if (mem_ack) begin
            dm_rdata <= mem_we ? '0 : mem_rdata;
            dm_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end else if (timeout) begin
            dm_rdata <= DATA_W'(BUS_ERR_DATA);
            dm_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the shared memory port.
module tb_mips_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, core_stall, bus_err;

  mips_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .core_stall(core_stall), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction model: who owns the memory, what was latched, what completes next.
  int          m_owner;
  int          m_streak;
  int          m_busy_edges;
  logic [31:0] m_addr, m_wdata;
  logic        m_we;
  logic        exp_ifv, exp_dmv, exp_bus_err;
  logic [31:0] exp_ifr, exp_dmr;
  int          g_if, g_dm, obs_if_g;
  logic        prev_mem_req;

  // Stimulus policy: 0 manual, 1 drop on valid, 2 renew on valid, 3 random.
  int          if_mode, dm_mode;
  int          ack_lat, ack_cur, busy_seen;
  bit          spur_en, force_ack;
  logic [31:0] memarr [logic [31:0]];

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memarr.exists(a)) return memarr[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_owner = 0; m_streak = 0; m_busy_edges = 0;
    m_addr = '0; m_wdata = '0; m_we = 1'b0;
    exp_ifv = 1'b0; exp_dmv = 1'b0; exp_ifr = '0; exp_dmr = '0; exp_bus_err = 1'b0;
    prev_mem_req = 1'b0; busy_seen = 0;
  endtask

  // Advance the model over one clock edge using the inputs the DUT just sampled.
  task automatic modelStep();
    bit ie, de;
    logic nifv, ndmv;
    nifv = 1'b0; ndmv = 1'b0;
    if (m_owner == 0) begin
      ie = if_req && !exp_ifv;
      de = dm_req && !exp_dmv;
      if (de && !(ie && m_streak == 4)) begin
        m_owner = 2; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
        m_streak = if_req ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
        m_busy_edges = 0; g_dm++;
      end else if (ie) begin
        m_owner = 1; m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
        m_streak = 0; m_busy_edges = 0; g_if++;
      end
    end else begin
      m_busy_edges++;
      if (mem_ack) begin
        if (m_owner == 1) begin nifv = 1'b1; exp_ifr = mem_rdata; end
        else begin ndmv = 1'b1; exp_dmr = m_we ? 32'h0 : mem_rdata; end
        m_owner = 0;
      end
`ifdef MIPS_MEM_TIMEOUT_EN
      else if (m_busy_edges == 255) begin
        if (m_owner == 1) begin nifv = 1'b1; exp_ifr = 32'hDEAD_BEEF; end
        else begin ndmv = 1'b1; exp_dmr = 32'hDEAD_BEEF; end
        exp_bus_err = 1'b1;
        m_owner = 0;
      end
`endif
    end
    exp_ifv = nifv;
    exp_dmv = ndmv;
  endtask

  task automatic applyStimulus();
    if (if_req && if_valid) begin
      if (if_mode == 1 || (if_mode == 3 && $urandom_range(0, 1) == 0)) if_req = 1'b0;
      else if (if_mode == 2) if_addr = 32'h200 + 32'($urandom_range(0, 63) << 2);
      else if (if_mode == 3) if_addr = 32'h400 + 32'($urandom_range(0, 15) << 2);
    end else if (!if_req && if_mode == 3 && $urandom_range(0, 2) == 0) begin
      if_req = 1'b1; if_addr = 32'h400 + 32'($urandom_range(0, 15) << 2);
    end
    if (dm_req && dm_valid) begin
      if (dm_mode == 1 || (dm_mode == 3 && $urandom_range(0, 1) == 0)) dm_req = 1'b0;
      else if (dm_mode == 2) dm_addr = 32'h300 + 32'($urandom_range(0, 63) << 2);
      else if (dm_mode == 3) begin
        dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        dm_addr = 32'h400 + 32'($urandom_range(0, 15) << 2);
      end
    end else if (!dm_req && dm_mode == 3 && $urandom_range(0, 2) == 0) begin
      dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
      dm_addr = 32'h400 + 32'($urandom_range(0, 15) << 2);
    end
    // Memory side: variable-latency acknowledge, occasional stray acks while idle.
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (mem_req) begin
      busy_seen++;
      if (busy_seen == 1) ack_cur = (ack_lat == 0) ? $urandom_range(1, 4) : ack_lat;
      if (ack_cur > 0 && busy_seen == ack_cur) begin
        mem_ack = 1'b1;
        if (mem_we) memarr[mem_addr] = mem_wdata;
        else mem_rdata = memRead(mem_addr);
      end
    end else begin
      busy_seen = 0;
      if (force_ack || (spur_en && $urandom_range(0, 3) == 0)) mem_ack = 1'b1;
      force_ack = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    modelStep();
    checkOutput("mem_req", mem_req, m_owner != 0);
    checkOutput("mem_we", mem_we, (m_owner != 0) ? m_we : mem_we);
    if (m_owner != 0) checkOutput("mem_addr", mem_addr, m_addr);
    if (m_owner == 2) checkOutput("mem_wdata", mem_wdata, m_wdata);
    checkOutput("if_valid", if_valid, exp_ifv);
    checkOutput("dm_valid", dm_valid, exp_dmv);
    checkOutput("if_rdata", if_rdata, exp_ifr);
    checkOutput("dm_rdata", dm_rdata, exp_dmr);
    checkOutput("core_stall", core_stall, (if_req && !exp_ifv) || (dm_req && !exp_dmv));
    checkOutput("bus_err", bus_err, exp_bus_err);
    if (mem_req && !prev_mem_req && mem_addr[11:8] == 4'h2) obs_if_g++;
    prev_mem_req = mem_req;
    applyStimulus();
  endtask

  task automatic drain();
    if_mode = 1; dm_mode = 1; ack_lat = 2; spur_en = 0;
    for (int i = 0; i < 40 && (if_req || dm_req || mem_req); i++) tick();
    checkOutput("drain_idle", {if_req, dm_req, mem_req}, 3'b000);
  endtask

  initial begin
    automatic int lat = 0;
    automatic bit seen = 0;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    mem_ack = 0; mem_rdata = 0; if_mode = 0; dm_mode = 0; ack_lat = 2; ack_cur = 0;
    spur_en = 0; force_ack = 0; g_if = 0; g_dm = 0; obs_if_g = 0;
    memarr[32'h40] = 32'h2402_0005;
    modelReset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {if_valid, dm_valid, mem_req, mem_we, core_stall, bus_err}, 6'b0);
    checkOutput("reset_rdata", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] single IF fetch, ack latency 3");
    tick();
    if_req = 1; if_addr = 32'h40; if_mode = 1; ack_lat = 3;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      tick();
      if (if_valid) lat = i;
    end
    checkOutput("t1_latency", lat, 4);
    checkOutput("t1_if_rdata", if_rdata, 32'h2402_0005);
    drain();

    $display("[TB] simultaneous IF and DM write");
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 1; dm_addr = 32'h100;
    dm_wdata = 32'hCAFE_F00D; ack_lat = 2;
    tick();
    checkOutput("t2_dm_first_we", mem_we, 1'b1);
    checkOutput("t2_dm_first_addr", mem_addr, 32'h100);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = dm_valid; end
    checkOutput("t2_dm_done", seen, 1'b1);
    tick();
    checkOutput("t2_if_next_req", mem_req, 1'b1);
    checkOutput("t2_if_next_addr", mem_addr, 32'h44);
    drain();
    checkOutput("t2_mem_written", memRead(32'h100), 32'hCAFE_F00D);

    $display("[TB] stray mem_ack while idle");
    force_ack = 1;
    tick();
    tick();
    checkOutput("t6_no_valid", {if_valid, dm_valid, mem_req}, 3'b000);

    $display("[TB] IF held while DM re-requests, ack latency 1");
    g_if = 0; g_dm = 0; obs_if_g = 0;
    if_req = 1; if_addr = 32'h200; if_mode = 2;
    dm_req = 1; dm_we = 0; dm_addr = 32'h300; dm_mode = 2; ack_lat = 1;
    repeat (40) tick();
    checkOutput("t3_if_grants", obs_if_g, g_if);
    checkOutput("t3_if_not_starved", g_if > 0, 1'b1);
    drain();

    $display("[TB] random traffic");
    if_mode = 3; dm_mode = 3; ack_lat = 0; spur_en = 1;
    repeat (400) tick();
    drain();

    $display("[TB] reset during DM access");
    dm_req = 1; dm_we = 0; dm_addr = 32'h104; dm_mode = 1; ack_lat = -1;
    repeat (3) tick();
    checkOutput("t4_busy_before", mem_req, 1'b1);
    #2 rst_n = 1'b0;
    if_req = 1; if_addr = 32'h48; if_mode = 1;
    #1;
    checkOutput("t4_async_clear", {mem_req, dm_valid, core_stall}, 3'b000);
    modelReset();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    ack_lat = 2;
    tick();
    checkOutput("t4_first_grant", mem_addr, 32'h104);
    drain();

`ifdef MIPS_MEM_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    if_req = 1; if_addr = 32'h4C; if_mode = 1; ack_lat = -1;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin tick(); seen = if_valid; end
    checkOutput("t5_valid", seen, 1'b1);
    checkOutput("t5_rdata", if_rdata, 32'hDEAD_BEEF);
    checkOutput("t5_bus_err", bus_err, 1'b1);
    repeat (5) tick();
    drain();
    checkOutput("t5_sticky", bus_err, 1'b1);
`else
    checkOutput("bus_err_tied", bus_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, observed running, expected done");
    $fatal(1, "[TB] global timeout");
  end

endmodule
